// File: rtl/abc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// abc_rr_arbiter
//
// Round-robin arbiter that shares one state-machine resource between three
// requesters A, B and C. A grant is held until the resource reports done, the
// grantee drops its request, or MAX_HOLD cycles have elapsed. Every release is
// followed by one dead REL cycle (grant=000) so the resource can turn around.
//
// State table:
//   state  | code | meaning
//   IDLE   | 000  | nothing granted, arbitrate every edge
//   GNT_A  | 001  | requester A owns the resource
//   GNT_B  | 010  | requester B owns the resource
//   GNT_C  | 011  | requester C owns the resource
//   REL    | 100  | one-cycle turnaround after a release, then arbitrate
//   (101-111 are illegal and fall back to IDLE)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active low
//   A, B, C  in   requests from requesters 0, 1, 2
//   done     in   one-cycle completion pulse from the shared resource
//   grant    out  one-hot grant {C,B,A}, registered
//   state    out  current state code, registered
//   y        out  resource enable (|grant), registered
//   timeout  out  one-cycle pulse on a release forced by MAX_HOLD
// ---------------------------------------------------------------------------
module abc_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       done,
    output logic [2:0] grant,
    output logic [2:0] state,
    output logic       y,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        GNT_A = 3'b001,
        GNT_B = 3'b010,
        GNT_C = 3'b011,
        REL   = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Requester indices; the pointer holds the index of the last grantee.
    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic             y_q, y_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [2:0]       req;
    logic             arb_hit;
    logic [1:0]       arb_idx;
    logic [1:0]       cur_idx;
    logic             rel_done, rel_drop, rel_max;

    assign req = {C, B, A};

    // Round-robin pick: search starts at the requester after the last grantee.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = IDX_A;
        unique case (last_q)
            IDX_A: begin
                if (req[1])      begin arb_hit = 1'b1; arb_idx = IDX_B; end
                else if (req[2]) begin arb_hit = 1'b1; arb_idx = IDX_C; end
                else if (req[0]) begin arb_hit = 1'b1; arb_idx = IDX_A; end
            end
            IDX_B: begin
                if (req[2])      begin arb_hit = 1'b1; arb_idx = IDX_C; end
                else if (req[0]) begin arb_hit = 1'b1; arb_idx = IDX_A; end
                else if (req[1]) begin arb_hit = 1'b1; arb_idx = IDX_B; end
            end
            default: begin
                if (req[0])      begin arb_hit = 1'b1; arb_idx = IDX_A; end
                else if (req[1]) begin arb_hit = 1'b1; arb_idx = IDX_B; end
                else if (req[2]) begin arb_hit = 1'b1; arb_idx = IDX_C; end
            end
        endcase
    end

    // GNT_A/B/C codes are index+1, so the grantee index falls out of the code.
    assign cur_idx  = 2'(state_q[1:0] - 2'd1);
    assign rel_done = done;
    assign rel_drop = ~req[cur_idx];
    assign rel_max  = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d   = IDLE;
        grant_d   = 3'b000;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;

        unique case (state_q)
            IDLE, REL: begin
                cnt_d = '0;
                if (arb_hit) begin
                    state_d = state_t'({1'b0, 2'(arb_idx + 2'd1)});
                    grant_d = 3'b001 << arb_idx;
                end
            end
            GNT_A, GNT_B, GNT_C: begin
                if (rel_done || rel_drop || rel_max) begin
                    state_d   = REL;
                    last_d    = cur_idx;
                    cnt_d     = '0;
                    // Only a pure hold-time expiry counts as a timeout.
                    timeout_d = rel_max && !rel_done && !rel_drop;
                end else begin
                    state_d = state_q;
                    grant_d = 3'b001 << cur_idx;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        y_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            y_q       <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= IDX_C;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            y_q       <= y_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign grant   = grant_q;
    assign state   = state_q;
    assign y       = y_q;
    assign timeout = timeout_q;

endmodule

// File: doc/abc_rr_arbiter.md
Name: abc_rr_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one state-machine resource between three requesters A, B and C.
- Grants exactly one requester at a time and holds the grant until one of three things happens: the resource signals done, the grantee drops its request, or a maximum hold time expires.
- Exposes its state code and a resource-enable output in the same style as the lab's other state machines.
- Sits between the request sources and the shared SM block; its grant/enable lines drive the resource.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a grant may stay active (legal range 2..255).
- CNT_W, 8, width of the internal hold counter (must satisfy 2^CNT_W > MAX_HOLD).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- A  input  1  request from requester 0.
- B  input  1  request from requester 1.
- C  input  1  request from requester 2.
- done  input  1  one-cycle completion pulse from the shared resource.
- grant  output  3  one-hot grant {C,B,A}; registered.
- state  output  3  current FSM state code; registered.
- y  output  1  resource enable, equal to |grant; registered.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset: rising edge with rst=0 sets state=3'b000, grant=3'b000, y=0, timeout=0, hold count=0, last-grantee pointer=C.
  - With this pointer, A has top priority after reset.
  - Reset overrides every other input, including mid-grant.
- State codes: IDLE=000, GNT_A=001, GNT_B=010, GNT_C=011, REL=100. Codes 101–111 are illegal and return to IDLE on the next edge.
- Arbitration (from IDLE or REL):
  - Search order starts at the requester after the last grantee: last=A gives B,C,A; last=B gives C,A,B; last=C gives A,B,C.
  - The first asserted request wins. Next state is GNT_x, grant=onehot(x), y=1, count=0.
  - If no request is asserted, next state is IDLE.
- Latency: a request sampled at edge N produces grant/y high immediately after edge N (same edge that changes the state).
- GNT_x behaviour:
  - Each edge evaluates the release conditions below; if none is true, count increments and the grant holds.
  - Release condition (a): done=1.
  - Release condition (b): the grantee's own request is 0.
  - Release condition (c): count==MAX_HOLD-1.
  - A grant is therefore visible for at most MAX_HOLD cycles.
- On release: next state is REL, grant=000, y=0, last=x.
  - timeout=1 for that one cycle only when (c) holds and neither (a) nor (b) holds.
  - Priority on the same edge: done > request drop > timeout.
- REL: lasts exactly one cycle with grant=000 as a dead/turnaround cycle for the resource, then arbitrates as IDLE does.
- Non-grantee requests are ignored during GNT_x; they only matter at arbitration.
- done outside GNT states is ignored.
- timeout is 0 in every cycle other than the forced-release cycle.
- Pointer updates only on release, not on grant.

Test Plan:
1. Reset: rst=0 for 2 edges with A=B=C=1 → grant=000, state=000, y=0, timeout=0. After rst=1, the first edge gives grant=001, state=001.
2. Done release: only A=1 held; done pulse on the 3rd grant cycle → grant=001 for 3 cycles, then state=100 with grant=000 for 1 cycle, then grant=001 again (sole requester); timeout stays 0.
3. Full contention, MAX_HOLD=4, A=B=C=1 constant → A 4 cycles, REL, B 4 cycles, REL, C 4 cycles, REL, A. timeout pulses on each of the 3 REL entries.
4. Request drop: only B=1; B deasserted after 2 grant cycles → next edge state=100, timeout=0, then IDLE (000).
5. Simultaneous release causes: done=1 on the same edge as count==MAX_HOLD-1 → state=100, timeout=0.
6. Reset mid-grant: rst=0 during GNT_C, then A=C=1 after release → state=000 on the reset edge, then A granted first (pointer=C), then C after A releases.
